// File: rtl/tlb_search_arbiter.sv
// Arbiter sharing one combinational TLB search port among fetch (0), load/store (1) and TLBSRCH (2).
// Each lookup runs IDLE -> SEARCH -> RESP; fetch is promoted after STARVE_LIMIT lost arbitrations.
module tlb_search_arbiter #(
   parameter int  TLBNUM       = 16,
   parameter int  STARVE_LIMIT = 8,
   localparam int IW           = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [2:0]    req_valid,
   output logic [2:0]    req_ready,
   input  logic [56:0]   req_vppn,
   input  logic [2:0]    req_va12,
   input  logic [29:0]   req_asid,
   input  logic [2:0]    flush,
   output logic [18:0]   s_vppn,
   output logic          s_va_bit12,
   output logic [9:0]    s_asid,
   input  logic          s_found,
   input  logic [IW-1:0] s_index,
   input  logic [19:0]   s_ppn,
   input  logic [5:0]    s_ps,
   input  logic [1:0]    s_plv,
   input  logic [1:0]    s_mat,
   input  logic          s_d,
   input  logic          s_v,
   output logic [2:0]    resp_valid,
   input  logic [2:0]    resp_ready,
   output logic          resp_found,
   output logic [IW-1:0] resp_index,
   output logic [19:0]   resp_ppn,
   output logic [5:0]    resp_ps,
   output logic [1:0]    resp_plv,
   output logic [1:0]    resp_mat,
   output logic          resp_d,
   output logic          resp_v,
   output logic          busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;
   localparam int         SW        = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam int         RW        = IW + 33;

   logic [1:0]    state_q, state_d;
   logic [1:0]    id_q, id_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [18:0]   vppn_q, vppn_d;
   logic          va12_q, va12_d;
   logic [9:0]    asid_q, asid_d;
   logic [RW-1:0] res_q, res_d;

   logic [2:0] avail_s;
   logic       win_vld_s;
   logic [1:0] win_s;
   logic [2:0] owner_s;
   logic       flush_own_s;
   logic       ready_own_s;

   // Arbitration: fetch override when starved, else fixed priority 2 > 1 > 0 among unflushed requests.
   always_comb begin
      avail_s   = req_valid & ~flush;
      win_vld_s = 1'b1;
      win_s     = 2'd0;
      if ((starve_q == STARVE_MAX) && avail_s[0]) begin
         win_s = 2'd0;
      end else if (avail_s[2]) begin
         win_s = 2'd2;
      end else if (avail_s[1]) begin
         win_s = 2'd1;
      end else if (avail_s[0]) begin
         win_s = 2'd0;
      end else begin
         win_vld_s = 1'b0;
      end
      owner_s     = 3'b001 << id_q;
      flush_own_s = |(flush & owner_s);
      ready_own_s = |(resp_ready & owner_s);
   end

   // Next-state logic for the lookup sequencer, search registers, result registers and starve counter.
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      starve_d = starve_q;
      vppn_d   = vppn_q;
      va12_d   = va12_q;
      asid_d   = asid_q;
      res_d    = res_q;
      case (state_q)
         ST_IDLE: begin
            if (win_vld_s) begin
               state_d = ST_SEARCH;
               id_d    = win_s;
               case (win_s)
                  2'd2: begin
                     vppn_d = req_vppn[56:38];
                     va12_d = req_va12[2];
                     asid_d = req_asid[29:20];
                  end
                  2'd1: begin
                     vppn_d = req_vppn[37:19];
                     va12_d = req_va12[1];
                     asid_d = req_asid[19:10];
                  end
                  default: begin
                     vppn_d = req_vppn[18:0];
                     va12_d = req_va12[0];
                     asid_d = req_asid[9:0];
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
            // A valid, unflushed fetch that does not win here necessarily lost to a higher requester.
            if (!req_valid[0] || (win_vld_s && (win_s == 2'd0))) begin
               starve_d = '0;
            end else if (avail_s[0] && (starve_q != STARVE_MAX)) begin
               starve_d = starve_q + SW'(1);
            end else begin
               starve_d = starve_q;
            end
         end
         ST_SEARCH: begin
            if (flush_own_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
               res_d   = {s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v};
            end
         end
         ST_RESP: begin
            if (ready_own_s || flush_own_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         id_q     <= 2'd0;
         starve_q <= '0;
         vppn_q   <= 19'd0;
         va12_q   <= 1'b0;
         asid_q   <= 10'd0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         starve_q <= starve_d;
         vppn_q   <= vppn_d;
         va12_q   <= va12_d;
         asid_q   <= asid_d;
         res_q    <= res_d;
      end
   end

   // Output decode from the registered state.
   always_comb begin
      req_ready  = ((state_q == ST_IDLE) && win_vld_s) ? (3'b001 << win_s) : 3'b000;
      resp_valid = (state_q == ST_RESP) ? owner_s : 3'b000;
      busy       = (state_q != ST_IDLE);
   end

   assign s_vppn     = vppn_q;
   assign s_va_bit12 = va12_q;
   assign s_asid     = asid_q;
   assign {resp_found, resp_index, resp_ppn, resp_ps, resp_plv, resp_mat, resp_d, resp_v} = res_q;

endmodule

// File: doc/tlb_search_arbiter.md
Name: tlb_search_arbiter

Overview:
- Shares the single TLB search port feeding address translation among three requesters: 0 = instruction fetch, 1 = load/store, 2 = TLBSRCH.
- Each lookup is sequenced through a 3-state FSM: grant and latch the request, drive the TLB for one cycle, then register and hold the result until the requester accepts it.
- Priority is fixed, with an anti-starvation override for fetch.
- Per-requester flush cancels in-flight work on pipeline redirects.

Parameters:
- TLBNUM, 16, number of TLB entries; index width is IW = $clog2(TLBNUM).
- STARVE_LIMIT, 8, consecutive lost IDLE arbitrations after which fetch is promoted to top priority.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  3  request valid, bit i = requester i.
- req_ready  out  3  one-hot grant; asserted only in IDLE.
- req_vppn  in  57  {vppn2, vppn1, vppn0}, 19 bits each.
- req_va12  in  3  VA bit 12 per requester.
- req_asid  in  30  {asid2, asid1, asid0}, 10 bits each.
- flush  in  3  cancel requester i's in-flight lookup or response.
- s_vppn  out  19  TLB search VPPN.
- s_va_bit12  out  1  TLB search VA bit 12.
- s_asid  out  10  TLB search ASID.
- s_found  in  1  TLB result (combinational, same cycle as search inputs).
- s_index  in  IW  TLB result.
- s_ppn  in  20  TLB result.
- s_ps  in  6  TLB result.
- s_plv  in  2  TLB result.
- s_mat  in  2  TLB result.
- s_d  in  1  TLB result.
- s_v  in  1  TLB result.
- resp_valid  out  3  one-hot response valid.
- resp_ready  in  3  response accept, bit i = requester i.
- resp_found, resp_index, resp_ppn, resp_ps, resp_plv, resp_mat, resp_d, resp_v  out  1/IW/20/6/2/2/1/1  registered lookup result.
- busy  out  1  state != IDLE.

Behaviour:
- Interface: one clock `clk`; reset `resetn` is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - req_ready = 0, resp_valid = 0, busy = 0.
  - All resp_* = 0; s_vppn, s_va_bit12, s_asid = 0.
  - Latched id = 0; starve_cnt = 0.
- Reset asserted mid-operation aborts immediately: no response is issued and the pending request is lost. Requesters must re-request.
- FSM states: IDLE, SEARCH, RESP.
- IDLE:
  - Winner w is chosen combinationally from req_valid & ~flush.
  - Normal priority: 2 > 1 > 0.
  - If starve_cnt == STARVE_LIMIT and req_valid[0], fetch wins regardless of the others.
  - req_ready = onehot(w), or 0 if there is no winner.
  - On handshake: latch id = w and the corresponding vppn/va12/asid into the s_* output registers; next state = SEARCH.
- SEARCH (exactly 1 cycle):
  - s_* registers are stable; the TLB is combinational.
  - At the clock edge, capture s_found..s_v into resp_* registers.
  - Next state = RESP, or IDLE if flush[id] is asserted this cycle (result discarded, resp_* not updated).
- RESP:
  - resp_valid = onehot(id); resp_* are held stable.
  - If resp_ready[id]: handshake completes, next state = IDLE.
  - Else if flush[id]: drop the response, next state = IDLE, resp_valid deasserts next cycle.
  - If resp_ready[id] and flush[id] are asserted together, the handshake counts as complete; the response is delivered.
  - resp_ready bits of non-owners are ignored.
- Latency and throughput:
  - req handshake at edge N, resp_valid high from cycle N+2 at the earliest.
  - Minimum 3 cycles per lookup; no new grant while busy.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each IDLE cycle where req_valid[0] && !flush[0] and the winner != 0.
  - Cleared when fetch is granted, or when req_valid[0] is low in IDLE.
  - Holds in SEARCH/RESP.
- s_* outputs hold their last granted values outside SEARCH.
- The TLB result is sampled only in SEARCH.
- Requesters must hold req_* stable while req_valid is high and not yet granted. A request dropped before grant is simply not served.
- flush[i] in IDLE masks requester i from arbitration that cycle.

Test Plan:
- Reset, then single fetch request (vppn=19'h00ABC, asid=10'h5, TLB returns found=1, index=3, ppn=20'h12345) -> req_ready=3'b001 at cycle 0; resp_valid=3'b001 at cycle 2 with resp_index=3, resp_ppn=20'h12345.
- All three requesters valid continuously, resp_ready tied high -> grants in order 2,2,...; fetch is granted on the 9th arbitration once starve_cnt reaches 8, and starve_cnt returns to 0 after that grant.
- Mem request granted, resp_ready[1] held low 5 cycles -> resp_valid=3'b010 and resp_* stable for all 5 cycles; no req_ready during that time; busy=1.
- flush[0] asserted in SEARCH for a fetch lookup -> no resp_valid; state IDLE next cycle; pending mem request granted the following cycle.
- resp_ready[2] and flush[2] high in the same RESP cycle -> handshake completes; back to IDLE; no duplicate response.
- resetn pulled low during RESP -> resp_valid=0 and s_*=0 immediately (asynchronous); after release, busy=0 and no response is issued until a new request arrives.
